led_page_scan_reader: RTL and testbench

- Read-side engine for the 128-page LED frame buffer.
- Walks every page of the buffer in order and issues byte reads on the buffer's read port.
- Serialises each byte MSB-first onto the LED driver shift chain, then latches the page and enables display for a fixed on-time.
- Sits between the frame buffer's read port and the LED panel driver pins; it is the consumer of the data the host-side logic writes.

---
 rtl/led_page_scan_reader.sv | 254 +++++++++++++++++++++++++
 tb/tb_led_page_scan_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_page_scan_reader.sv
// led_page_scan_reader
// ----------------------------------------------------------------------------
// Read-side scan engine for the 128-page LED frame buffer. On a start request
// it walks pages 0..127. For each page it reads 36 bytes from the buffer's read
// port and shifts every byte MSB-first into the LED driver chain. It then
// pulses the latch and enables the panel for a fixed on-time.
//
// Ports
//   rdclock     in   1   single clock for the whole block
//   rst         in   1   synchronous, active-high reset
//   start       in   1   one-cycle frame-start request
//   rdaddress   out 13   frame buffer read address {page, block, sub}
//   q           in   8   frame buffer read data (valid RD_LAT cycles after address)
//   led_sdo     out  1   serial data to the driver chain
//   led_sclk    out  1   shift clock, driver samples on its rising edge
//   led_lat     out  1   latch pulse, active-high
//   led_oe_n    out  1   output enable, active-low
//   page_idx    out  7   page currently being shifted or displayed
//   busy        out  1   frame in progress
//   frame_done  out  1   one-cycle pulse after page 127's display time
//   dbg_state   out  3   current FSM state (IDLE=0 FETCH=1 SHIFT=2 LATCH=3 DISPLAY=4)
//
// Handshake: start is a request without back-pressure. It is accepted only on
// an edge where the FSM is IDLE and frame_done is low. busy rises on that same
// edge and stays high until the edge that raises frame_done. A start seen at
// any other time is dropped with no effect.
// ----------------------------------------------------------------------------
module led_page_scan_reader #(
    parameter int RD_LAT   = 2,
    parameter int SCLK_DIV = 1,
    parameter int LAT_W    = 2,
    parameter int OE_W     = 64
) (
    input  logic        rdclock,
    input  logic        rst,
    input  logic        start,
    output logic [12:0] rdaddress,
    input  logic [7:0]  q,
    output logic        led_sdo,
    output logic        led_sclk,
    output logic        led_lat,
    output logic        led_oe_n,
    output logic [6:0]  page_idx,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SHIFT   = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    // One shared 12-bit timer covers the longest phase (OE_W up to 4095).
    localparam logic [11:0] C_FETCH_LAST = 12'(RD_LAT);
    localparam logic [11:0] C_HALF_LAST  = 12'(SCLK_DIV - 1);
    localparam logic [11:0] C_LAT_LAST   = 12'(LAT_W - 1);
    localparam logic [11:0] C_OE_LAST    = 12'(OE_W - 1);
    localparam logic [5:0]  C_BYTE_LAST  = 6'd35;
    localparam logic [6:0]  C_PAGE_LAST  = 7'd127;
    localparam logic [2:0]  C_BIT_LAST   = 3'd7;

    state_t      r_state;
    logic [6:0]  r_page;
    logic [5:0]  r_byte;
    logic [2:0]  r_bit;
    logic [11:0] r_timer;
    logic [6:0]  r_shreg;   // bits still to be shifted; the MSB is already on led_sdo
    logic [12:0] r_addr;
    logic        r_sdo;
    logic        r_sclk;
    logic        r_lat;
    logic        r_oe_n;
    logic        r_busy;
    logic        r_done;

    state_t      w_state;
    logic [6:0]  w_page;
    logic [5:0]  w_byte;
    logic [2:0]  w_bit;
    logic [11:0] w_timer;
    logic [6:0]  w_shreg;
    logic [12:0] w_addr;
    logic        w_sdo;
    logic        w_sclk;
    logic        w_lat;
    logic        w_oe_n;
    logic        w_busy;
    logic        w_done;

    logic [11:0] w_timer_inc;
    logic [5:0]  w_byte_inc;
    logic [6:0]  w_page_inc;

    assign w_timer_inc = r_timer + 12'd1;
    assign w_byte_inc  = r_byte + 6'd1;
    assign w_page_inc  = r_page + 7'd1;

    // Because b < 36, the byte index b is the same as {blk, sub} = {b/4, b%4}.
    // So the address is just {page, byte}, and the block field never exceeds 8.
    always_comb begin
        w_state = r_state;
        w_page  = r_page;
        w_byte  = r_byte;
        w_bit   = r_bit;
        w_timer = r_timer;
        w_shreg = r_shreg;
        w_addr  = r_addr;
        w_sdo   = r_sdo;
        w_sclk  = 1'b0;
        w_lat   = 1'b0;
        w_oe_n  = 1'b1;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The frame_done cycle is already IDLE, but a start there is dropped.
                if (start && !r_done) begin
                    w_state = S_FETCH;
                    w_page  = 7'd0;
                    w_byte  = 6'd0;
                    w_bit   = 3'd0;
                    w_timer = 12'd0;
                    w_addr  = 13'd0;
                    w_busy  = 1'b1;
                end
            end

            S_FETCH: begin
                // rdaddress is held for the whole state. q is taken on the last cycle.
                if (r_timer == C_FETCH_LAST) begin
                    w_state = S_SHIFT;
                    w_timer = 12'd0;
                    w_bit   = 3'd0;
                    w_sdo   = q[7];
                    w_shreg = q[6:0];
                end else begin
                    w_timer = w_timer_inc;
                end
            end

            S_SHIFT: begin
                w_sclk = r_sclk;
                if (r_timer != C_HALF_LAST) begin
                    w_timer = w_timer_inc;
                end else begin
                    w_timer = 12'd0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // End of a high phase: sclk drops. Data may move only now.
                        w_sclk = 1'b0;
                        if (r_bit != C_BIT_LAST) begin
                            w_bit   = r_bit + 3'd1;
                            w_sdo   = r_shreg[6];
                            w_shreg = {r_shreg[5:0], 1'b0};
                        end else if (r_byte != C_BYTE_LAST) begin
                            w_state = S_FETCH;
                            w_byte  = w_byte_inc;
                            w_addr  = {r_page, w_byte_inc};
                        end else begin
                            w_state = S_LATCH;
                            w_lat   = 1'b1;
                        end
                    end
                end
            end

            S_LATCH: begin
                if (r_timer == C_LAT_LAST) begin
                    w_state = S_DISPLAY;
                    w_timer = 12'd0;
                    w_oe_n  = 1'b0;
                end else begin
                    w_timer = w_timer_inc;
                    w_lat   = 1'b1;
                end
            end

            S_DISPLAY: begin
                if (r_timer == C_OE_LAST) begin
                    w_timer = 12'd0;
                    w_byte  = 6'd0;
                    w_bit   = 3'd0;
                    if (r_page != C_PAGE_LAST) begin
                        w_state = S_FETCH;
                        w_page  = w_page_inc;
                        w_addr  = {w_page_inc, 6'd0};
                    end else begin
                        w_state = S_IDLE;
                        w_page  = 7'd0;
                        w_addr  = 13'd0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_timer = w_timer_inc;
                    w_oe_n  = 1'b0;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rdclock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 7'd0;
            r_byte  <= 6'd0;
            r_bit   <= 3'd0;
            r_timer <= 12'd0;
            r_shreg <= 7'd0;
            r_addr  <= 13'd0;
            r_sdo   <= 1'b0;
            r_sclk  <= 1'b0;
            r_lat   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_page  <= w_page;
            r_byte  <= w_byte;
            r_bit   <= w_bit;
            r_timer <= w_timer;
            r_shreg <= w_shreg;
            r_addr  <= w_addr;
            r_sdo   <= w_sdo;
            r_sclk  <= w_sclk;
            r_lat   <= w_lat;
            r_oe_n  <= w_oe_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign rdaddress  = r_addr;
    assign led_sdo    = r_sdo;
    assign led_sclk   = r_sclk;
    assign led_lat    = r_lat;
    assign led_oe_n   = r_oe_n;
    assign page_idx   = r_page;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_led_page_scan_reader.sv
// tb_led_page_scan_reader
// Directed bench for led_page_scan_reader. A one-cycle-latency buffer model is
// used, with a short on-time, so that a full 128-page frame fits in the run.
// Expected timing for these parameters:
//   byte  = RD_LAT+1 + 16*SCLK_DIV = 2 + 16        = 18 cycles
//   page  = 36*18 + LAT_W + OE_W   = 648 + 3 + 5   = 656 cycles
//   frame = 128*656                                = 83968 cycles
module tb_led_page_scan_reader;

    localparam int RD_LAT   = 1;
    localparam int SCLK_DIV = 1;
    localparam int LAT_W    = 3;
    localparam int OE_W     = 5;
    localparam int FIRST_RISE = 3;      // RD_LAT+1+SCLK_DIV cycles after FETCH entry
    localparam int PAGE_CYC   = 656;
    localparam int FRAME_CYC  = 83968;
    localparam int W = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] rdaddress;
    logic [7:0]  q = 8'd0;
    logic        led_sdo, led_sclk, led_lat, led_oe_n;
    logic [6:0]  page_idx;
    logic        busy, frame_done;
    logic [2:0]  dbg_state;

    led_page_scan_reader #(
        .RD_LAT(RD_LAT), .SCLK_DIV(SCLK_DIV), .LAT_W(LAT_W), .OE_W(OE_W)
    ) u_dut (
        .rdclock(clk), .rst(rst), .start(start), .rdaddress(rdaddress), .q(q),
        .led_sdo(led_sdo), .led_sclk(led_sclk), .led_lat(led_lat), .led_oe_n(led_oe_n),
        .page_idx(page_idx), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter / buffer model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:8191];
    always @(posedge clk) q <= mem[rdaddress];

    // ---------------- monitor (samples on the falling edge) ----------------
    logic        rise_bit [0:39999];
    int          rise_cyc [0:39999];
    logic [12:0] addr_log [0:8191];
    int page_cyc [0:127];
    int lat_rise [0:127];
    int lat_cnt  [0:127];
    int oe_cnt   [0:127];
    int n_rise = 0, n_addr = 0, n_bad_addr = 0, n_sdo_glitch = 0;
    int n_step_bad = 0, n_done = 0, done_cyc = 0, n_oe_total = 0;
    logic        m_sclk = 1'b0, m_sdo = 1'b0, m_lat = 1'b0, m_busy = 1'b0;
    logic [12:0] m_addr = 13'd0;
    logic [6:0]  m_page = 7'd0;

    initial begin
        for (int i = 0; i < 128; i++) begin
            page_cyc[i] = 0; lat_rise[i] = 0; lat_cnt[i] = 0; oe_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (led_sclk && !m_sclk) begin
            if (n_rise < 40000) begin
                rise_bit[n_rise] = led_sdo;
                rise_cyc[n_rise] = cyc;
            end
            n_rise++;
        end
        if (led_sdo != m_sdo && led_sclk) n_sdo_glitch++;
        if (rdaddress != m_addr) begin
            if (n_addr < 8192) addr_log[n_addr] = rdaddress;
            n_addr++;
        end
        if (rdaddress[5:2] > 4'd8) n_bad_addr++;
        if (busy && !m_busy) page_cyc[0] = cyc;
        if (busy && page_idx != m_page) begin
            if (page_idx != m_page + 7'd1) n_step_bad++;
            page_cyc[page_idx] = cyc;
        end
        if (led_lat) begin
            lat_cnt[page_idx]++;
            if (!m_lat) lat_rise[page_idx] = cyc;
        end
        if (!led_oe_n) begin
            oe_cnt[page_idx]++;
            n_oe_total++;
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        m_sclk = led_sclk; m_sdo = led_sdo; m_lat = led_lat;
        m_busy = busy; m_addr = rdaddress; m_page = page_idx;
    end

    // ---------------- scoreboard / checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_rise < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, (n_rise >= target) ? 1 : 0, 1);
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 8; i++) v = {v[6:0], rise_bit[idx + i]};
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_addr"},  32'(rdaddress), 0);
        check({tag, "_sdo"},   32'(led_sdo), 0);
        check({tag, "_sclk"},  32'(led_sclk), 0);
        check({tag, "_lat"},   32'(led_lat), 0);
        check({tag, "_oe_n"},  32'(led_oe_n), 1);
        check({tag, "_page"},  32'(page_idx), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(frame_done), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // ---------------- directed sequence ----------------
    int acc, r0, r1, oe0, errs, idx, got;
    logic [W-1:0] e;

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 8'(a * 7 + 3);
        mem[0] = 8'hA5;
        for (int b = 0; b < 36; b++) mem[{7'd5, 6'(b)}] = 8'(b + 1);

        // Reset / idle
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check_idle("reset");
        check("reset_no_sclk", n_rise, 0);
        check("reset_no_oe", n_oe_total, 0);

        // Single byte: address 0 held through FETCH, then A5 MSB-first
        r0 = n_rise;
        oe0 = n_oe_total;
        pulse_start();
        acc = cyc;
        check("start_busy", 32'(busy), 1);
        check("fetch_addr_c0", 32'(rdaddress), 0);
        check("fetch_state", 32'(dbg_state), 1);
        tick();
        check("fetch_addr_c1", 32'(rdaddress), 0);
        tick();
        check("shift_state", 32'(dbg_state), 2);
        wait_rises(r0 + 8, 100, "wait_first_byte");
        check("first_byte_bits", 32'(byte_at(r0)), 'hA5);
        check("first_rise_delay", rise_cyc[r0] - acc, FIRST_RISE);

        // Full frame, with a start request dropped in the middle
        got = 0;
        for (int k = 0; k < 90000 && got == 0; k++) begin
            tick();
            if (k == 1000) start = 1'b1;
            if (k == 1001) begin
                start = 1'b0;
                check("busy_mid_frame", 32'(busy), 1);
            end
            if (frame_done) got = 1;
        end
        check("frame_done_seen", got, 1);
        check("frame_done_cycle", done_cyc - acc, FRAME_CYC);
        check("frame_done_busy", 32'(busy), 0);

        // A start in the frame_done cycle is ignored
        pulse_start();
        check("done_start_ignored_busy", 32'(busy), 0);
        check("done_start_ignored_state", 32'(dbg_state), 0);
        check("done_pulse_one_cycle", 32'(frame_done), 0);
        check("done_count", n_done, 1);

        // Page timing
        check("page1_start", page_cyc[1] - acc, PAGE_CYC);
        errs = 0;
        for (int p = 1; p < 128; p++) if (page_cyc[p] - page_cyc[p-1] != PAGE_CYC) errs++;
        check("page_period_errs", errs, 0);
        check("page_step_errs", n_step_bad, 0);
        check("p5_lat_width", lat_cnt[5], LAT_W);
        check("p5_oe_width", oe_cnt[5], OE_W);
        check("p5_lat_after_last_rise", lat_rise[5] - rise_cyc[r0 + 5*288 + 287], SCLK_DIV);
        check("p127_oe_width", oe_cnt[127], OE_W);
        errs = 0;
        for (int p = 0; p < 128; p++) begin
            if (lat_cnt[p] != LAT_W) errs++;
            if (oe_cnt[p] != OE_W) errs++;
            if (lat_rise[p] - rise_cyc[r0 + p*288 + 287] != SCLK_DIV) errs++;
        end
        check("page_lat_oe_errs", errs, 0);
        check("frame_oe_total", n_oe_total - oe0, 128 * OE_W);
        check("frame_rise_total", n_rise - r0, 128 * 288);
        check("no_block_above_8", n_bad_addr, 0);
        check("sdo_stable_while_sclk_high", n_sdo_glitch, 0);

        // Address walk for page 5: 0x140..0x163 in order
        idx = -1;
        for (int i = 0; i < n_addr && i < 8192; i++) begin
            if (idx < 0 && addr_log[i] == 13'h140) idx = i;
        end
        check("p5_addr_found", (idx >= 0) ? 1 : 0, 1);
        if (idx >= 0) begin
            for (int b = 0; b < 36; b++) exp_q.push_back(W'(13'h140 + b));
            for (int b = 0; b < 36; b++) begin
                e = exp_q.pop_front();
                check($sformatf("p5_addr_%0d", b), 32'(addr_log[idx + b]), 32'(e));
            end
        end

        // Page 5 data reassembled from the captured rising-edge bits
        for (int b = 0; b < 36; b++) exp_q.push_back(W'(b + 1));
        for (int b = 0; b < 36; b++) begin
            e = exp_q.pop_front();
            check($sformatf("p5_byte_%0d", b), 32'(byte_at(r0 + 5*288 + 8*b)), 32'(e));
        end

        // Restart on the cycle after frame_done's cycle
        r1 = n_rise;
        pulse_start();
        check("restart_busy", 32'(busy), 1);
        check("restart_addr", 32'(rdaddress), 0);
        check("restart_state", 32'(dbg_state), 1);

        // Reset during page 3, byte 10, bit 4 (its high phase)
        wait_rises(r1 + 3*288 + 10*8 + 5, 3000, "wait_p3_b10_bit4");
        check("mid_page", 32'(page_idx), 3);
        check("mid_addr", 32'(rdaddress), 'h0CA);
        check("mid_sclk_high", 32'(led_sclk), 1);
        rst = 1'b1;
        tick();
        check_idle("midrst");
        rst = 1'b0;
        tick();
        r1 = n_rise;
        pulse_start();
        acc = cyc;
        check("rerun_addr", 32'(rdaddress), 0);
        wait_rises(r1 + 8, 100, "wait_rerun_byte");
        check("rerun_byte_bits", 32'(byte_at(r1)), 'hA5);
        check("rerun_first_rise", rise_cyc[r1] - acc, FIRST_RISE);
        check("rerun_page", 32'(page_idx), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
